axi_depacketizer: RTL and testbench

AXI_DEPACKETIZER -- requirements
Module: axi_depacketizer

---
 rtl/axi_depacketizer.sv | 218 +++++++++++++++++++++
 tb/tb_axi_depacketizer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_depacketizer.sv
// rtl/axi_depacketizer.sv - byte-stream packet parser that reassembles 32-bit samples
module axi_depacketizer #(
    parameter int DATA_W = 32,
    parameter int USER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [31:0]       pkt_timestamp,
    output logic [7:0]        pkt_channel,
    output logic [7:0]        pkt_count,
    output logic [15:0]       pkt_err_flags,
    output logic              pkt_done,
    output logic [2:0]        pkt_err,
    output logic [15:0]       good_cnt,
    output logic [15:0]       bad_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_TS, S_CHN, S_CNT, S_PAY, S_INFO, S_TERM, S_DROP
    } state_t;

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_HDR   = 3'd1;
    localparam logic [2:0] ERR_TRUNC = 3'd2;
    localparam logic [2:0] ERR_OVR   = 3'd3;
    localparam logic [2:0] ERR_TERM  = 3'd4;

    function automatic logic [7:0] hdr_byte(input logic [1:0] k);
        case (k)
            2'd0:    hdr_byte = 8'h44;
            2'd1:    hdr_byte = 8'h51;
            2'd2:    hdr_byte = 8'h41;
            default: hdr_byte = 8'h30;
        endcase
    endfunction

    state_t              r_state, w_next;
    logic [9:0]          r_idx;
    logic [23:0]         r_asm;
    logic [31:0]         r_ts;
    logic [7:0]          r_channel;
    logic [7:0]          r_count;
    logic [15:0]         r_flags;
    logic [15:0]         r_err_flags;
    logic [15:0]         r_good;
    logic [15:0]         r_bad;
    logic                r_rdy;
    logic                r_m_tvalid;
    logic [DATA_W-1:0]   r_m_tdata;
    logic [USER_W-1:0]   r_m_tuser;
    logic                r_m_tlast;

    logic                w_xfer;
    logic                w_done;
    logic [2:0]          w_err;
    logic                w_load;
    logic [7:0]          w_hdr_exp;
    logic                w_hdr_bad;
    logic                w_pay_last;
    logic [31:0]         w_word;

    assign s_axis_tready = r_rdy && ((r_state != S_PAY) || !r_m_tvalid || m_axis_tready);
    assign w_xfer        = s_axis_tvalid && s_axis_tready;
    assign w_hdr_exp     = (r_state == S_IDLE) ? 8'h44 : hdr_byte(r_idx[1:0] + 2'd1);
    assign w_hdr_bad     = (s_axis_tdata != w_hdr_exp);
    assign w_pay_last    = (r_idx == ({r_count, 2'b00} - 10'd1));
    assign w_word        = {s_axis_tdata, r_asm};

    // Byte index restarts whenever the state changes or a packet closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_xfer) begin
                r_state <= w_next;
                r_idx   <= (w_next != r_state || w_next == S_IDLE) ? 10'd0 : r_idx + 10'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_xfer) begin
            case (r_state)
                S_IDLE, S_HDR: begin
                    if (w_hdr_bad)
                        w_next = s_axis_tlast ? S_IDLE : S_DROP;
                    else if (s_axis_tlast)
                        w_next = S_IDLE;
                    else if (r_state == S_IDLE)
                        w_next = S_HDR;
                    else if (r_idx[1:0] == 2'd2)
                        w_next = S_TS;
                end
                S_TS:    w_next = s_axis_tlast ? S_IDLE : (r_idx[1:0] == 2'd3) ? S_CHN : S_TS;
                S_CHN:   w_next = s_axis_tlast ? S_IDLE : S_CNT;
                S_CNT:   w_next = s_axis_tlast ? S_IDLE : (s_axis_tdata == 8'd0) ? S_INFO : S_PAY;
                S_PAY:   w_next = s_axis_tlast ? S_IDLE : w_pay_last ? S_INFO : S_PAY;
                S_INFO:  w_next = s_axis_tlast ? S_IDLE : (r_idx[1:0] == 2'd3) ? S_TERM : S_INFO;
                S_TERM:  w_next = s_axis_tlast ? S_IDLE : S_DROP;
                S_DROP:  w_next = s_axis_tlast ? S_IDLE : S_DROP;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_done = 1'b0;
        w_err  = ERR_OK;
        w_load = 1'b0;
        if (w_xfer) begin
            case (r_state)
                S_IDLE, S_HDR: begin
                    if (w_hdr_bad) begin
                        w_done = 1'b1;
                        w_err  = ERR_HDR;
                    end else if (s_axis_tlast) begin
                        w_done = 1'b1;
                        w_err  = ERR_TRUNC;
                    end
                end
                S_TS, S_CHN, S_CNT, S_INFO: begin
                    w_done = s_axis_tlast;
                    w_err  = s_axis_tlast ? ERR_TRUNC : ERR_OK;
                end
                S_PAY: begin
                    w_done = s_axis_tlast;
                    w_err  = s_axis_tlast ? ERR_TRUNC : ERR_OK;
                    w_load = !s_axis_tlast && (r_idx[1:0] == 2'd3);
                end
                S_TERM: begin
                    w_done = 1'b1;
                    if (!s_axis_tlast)
                        w_err = ERR_OVR;
                    else if (s_axis_tdata != 8'h00)
                        w_err = ERR_TERM;
                end
                default: ;
            endcase
        end
    end

    // Payload and timestamp share the shift assembler; only the top 3 bytes need storing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm       <= '0;
            r_ts        <= '0;
            r_channel   <= '0;
            r_count     <= '0;
            r_flags     <= '0;
            r_err_flags <= '0;
            r_good      <= '0;
            r_bad       <= '0;
        end else begin
            if (w_xfer && (r_state == S_TS || r_state == S_PAY))
                r_asm <= {s_axis_tdata, r_asm[23:8]};
            if (w_xfer && r_state == S_TS && r_idx[1:0] == 2'd3)
                r_ts <= w_word;
            if (w_xfer && r_state == S_CHN)
                r_channel <= s_axis_tdata;
            if (w_xfer && r_state == S_CNT)
                r_count <= s_axis_tdata;
            if (w_xfer && r_state == S_INFO && r_idx[1:0] == 2'd0)
                r_flags[7:0] <= s_axis_tdata;
            if (w_xfer && r_state == S_INFO && r_idx[1:0] == 2'd1)
                r_flags[15:8] <= s_axis_tdata;
            if (w_done && w_err == ERR_OK) begin
                r_err_flags <= r_flags;
                if (r_good != 16'hFFFF)
                    r_good <= r_good + 16'd1;
            end
            if (w_done && w_err != ERR_OK && r_bad != 16'hFFFF)
                r_bad <= r_bad + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= DATA_W'(w_word);
            r_m_tuser  <= USER_W'(r_channel);
            r_m_tlast  <= w_pay_last;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;
    assign pkt_timestamp = r_ts;
    assign pkt_channel   = r_channel;
    assign pkt_count     = r_count;
    assign pkt_err_flags = r_err_flags;
    assign pkt_done      = w_done;
    assign pkt_err       = w_err;
    assign good_cnt      = r_good;
    assign bad_cnt       = r_bad;

endmodule

// File: tb/tb_axi_depacketizer.sv
// tb/tb_axi_depacketizer.sv - directed packet vectors with sample/result scoreboard
module tb_axi_depacketizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] m_tdata;
    logic [7:0]  m_tuser;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] pkt_timestamp;
    logic [7:0]  pkt_channel, pkt_count;
    logic [15:0] pkt_err_flags, good_cnt, bad_cnt;
    logic        pkt_done;
    logic [2:0]  pkt_err;

    always #5 clk = ~clk;

    axi_depacketizer #(.DATA_W(32), .USER_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .pkt_timestamp(pkt_timestamp), .pkt_channel(pkt_channel), .pkt_count(pkt_count),
        .pkt_err_flags(pkt_err_flags), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    typedef struct {
        logic [31:0]       ts;
        logic [7:0]        ch;
        logic [7:0]        n;
        logic [2:0][31:0]  s;
        logic [15:0]       flags;
        logic [7:0]        h2;
        logic [7:0]        term;
        logic              term_last;
        int                trunc;
        int                exp_err;
        int                exp_nsamp;
        logic [31:0]       exp_ts;
        logic [7:0]        exp_ch;
        logic [7:0]        exp_cnt;
        logic [15:0]       exp_flags;
        int                exp_good;
        int                exp_bad;
    } vec_t;

    vec_t        vecs[7];
    vec_t        v;
    logic [8:0]  bq[$];
    logic [31:0] mq_data[$];
    logic [7:0]  mq_user[$];
    logic        mq_last[$];
    int          dq_err[$];
    int          checks = 0;
    int          errors = 0;
    logic        saw_stall = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_d;
    logic [7:0]  prev_u;
    logic        prev_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            mq_data.push_back(m_tdata);
            mq_user.push_back(m_tuser);
            mq_last.push_back(m_tlast);
        end
        if (pkt_done)
            dq_err.push_back(32'(pkt_err));
        if (s_tvalid && !s_tready)
            saw_stall = 1'b1;
        if (prev_hold && m_tvalid) begin
            chk("hold_tdata", m_tdata, prev_d);
            chk("hold_tuser", 32'(m_tuser), 32'(prev_u));
            chk("hold_tlast", 32'(m_tlast), 32'(prev_l));
        end
        prev_hold = m_tvalid && !m_tready;
        prev_d    = m_tdata;
        prev_u    = m_tuser;
        prev_l    = m_tlast;
    end

    task automatic push(input logic last, input logic [7:0] b);
        bq.push_back({last, b});
    endtask

    task automatic build(input vec_t x);
        bq.delete();
        push(1'b0, 8'h44); push(1'b0, 8'h51); push(1'b0, x.h2); push(1'b0, 8'h30);
        for (int b = 0; b < 4; b++) push(1'b0, x.ts[8*b +: 8]);
        push(1'b0, x.ch);
        push(1'b0, x.n);
        for (int k = 0; k < 32'(x.n); k++)
            for (int b = 0; b < 4; b++) push(1'b0, x.s[k][8*b +: 8]);
        push(1'b0, x.flags[7:0]); push(1'b0, x.flags[15:8]); push(1'b0, 8'h00); push(1'b0, 8'h00);
        push(x.term_last, x.term);
        if (!x.term_last) begin
            push(1'b0, 8'hEE); push(1'b0, 8'hEE); push(1'b1, 8'hEE);
        end
        if (x.trunc >= 0) begin
            while (bq.size() > x.trunc + 1) void'(bq.pop_back());
            bq[x.trunc] = {1'b1, bq[x.trunc][7:0]};
        end
    endtask

    task automatic send_byte(input logic [8:0] w);
        int n = 0;
        s_tdata  = w[7:0];
        s_tlast  = w[8];
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_axis_tready stuck at %0d, required 1", s_tready);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_first(input int cnt);
        for (int i = 0; i < cnt && i < bq.size(); i++) send_byte(bq[i]);
    endtask

    task automatic clear_q();
        mq_data.delete(); mq_user.delete(); mq_last.delete(); dq_err.delete();
    endtask

    task automatic check_case(input string tag, input vec_t x);
        chk({tag, " done_count"}, 32'(dq_err.size()), 32'd1);
        if (dq_err.size() > 0)
            chk({tag, " pkt_err"}, 32'(dq_err[0]), 32'(x.exp_err));
        chk({tag, " nsamp"}, 32'(mq_data.size()), 32'(x.exp_nsamp));
        for (int k = 0; k < mq_data.size() && k < x.exp_nsamp; k++) begin
            chk($sformatf("%s samp%0d tdata", tag, k), mq_data[k], x.s[k]);
            chk($sformatf("%s samp%0d tuser", tag, k), 32'(mq_user[k]), 32'(x.ch));
            chk($sformatf("%s samp%0d tlast", tag, k), 32'(mq_last[k]), 32'(k == 32'(x.n) - 1));
        end
        chk({tag, " timestamp"}, pkt_timestamp, x.exp_ts);
        chk({tag, " channel"}, 32'(pkt_channel), 32'(x.exp_ch));
        chk({tag, " count"}, 32'(pkt_count), 32'(x.exp_cnt));
        chk({tag, " flags"}, 32'(pkt_err_flags), 32'(x.exp_flags));
        chk({tag, " good_cnt"}, 32'(good_cnt), 32'(x.exp_good));
        chk({tag, " bad_cnt"}, 32'(bad_cnt), 32'(x.exp_bad));
        clear_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{ts: 32'h12345678, ch: 8'h03, n: 8'd2, s: {32'h0, 32'h01020304, 32'hA1B2C3D4},
                    flags: 16'h00F0, h2: 8'h41, term: 8'h00, term_last: 1'b1, trunc: -1,
                    exp_err: 0, exp_nsamp: 2, exp_ts: 32'h12345678, exp_ch: 8'h03, exp_cnt: 8'd2,
                    exp_flags: 16'h00F0, exp_good: 1, exp_bad: 0};
        vecs[1] = '{ts: 32'hDEADBEEF, ch: 8'h09, n: 8'd1, s: {32'h0, 32'h0, 32'h11111111},
                    flags: 16'h1234, h2: 8'h42, term: 8'h00, term_last: 1'b1, trunc: -1,
                    exp_err: 1, exp_nsamp: 0, exp_ts: 32'h12345678, exp_ch: 8'h03, exp_cnt: 8'd2,
                    exp_flags: 16'h00F0, exp_good: 1, exp_bad: 1};
        vecs[2] = '{ts: 32'h00000001, ch: 8'h05, n: 8'd1, s: {32'h0, 32'h0, 32'hCAFEF00D},
                    flags: 16'hABCD, h2: 8'h41, term: 8'h00, term_last: 1'b1, trunc: -1,
                    exp_err: 0, exp_nsamp: 1, exp_ts: 32'h00000001, exp_ch: 8'h05, exp_cnt: 8'd1,
                    exp_flags: 16'hABCD, exp_good: 2, exp_bad: 1};
        vecs[3] = '{ts: 32'h0A0B0C0D, ch: 8'h11, n: 8'd3, s: {32'h0, 32'h99AABBCC, 32'h55667788},
                    flags: 16'h0000, h2: 8'h41, term: 8'h00, term_last: 1'b1, trunc: 16,
                    exp_err: 2, exp_nsamp: 1, exp_ts: 32'h0A0B0C0D, exp_ch: 8'h11, exp_cnt: 8'd3,
                    exp_flags: 16'hABCD, exp_good: 2, exp_bad: 2};
        vecs[4] = '{ts: 32'h00000010, ch: 8'h02, n: 8'd0, s: {32'h0, 32'h0, 32'h0},
                    flags: 16'h0F0F, h2: 8'h41, term: 8'h55, term_last: 1'b1, trunc: -1,
                    exp_err: 4, exp_nsamp: 0, exp_ts: 32'h00000010, exp_ch: 8'h02, exp_cnt: 8'd0,
                    exp_flags: 16'hABCD, exp_good: 2, exp_bad: 3};
        vecs[5] = '{ts: 32'h00000020, ch: 8'h04, n: 8'd0, s: {32'h0, 32'h0, 32'h0},
                    flags: 16'h0101, h2: 8'h41, term: 8'h00, term_last: 1'b0, trunc: -1,
                    exp_err: 3, exp_nsamp: 0, exp_ts: 32'h00000020, exp_ch: 8'h04, exp_cnt: 8'd0,
                    exp_flags: 16'hABCD, exp_good: 2, exp_bad: 4};
        vecs[6] = '{ts: 32'h87654321, ch: 8'h07, n: 8'd1, s: {32'h0, 32'h0, 32'h0BADC0DE},
                    flags: 16'h8001, h2: 8'h41, term: 8'h00, term_last: 1'b1, trunc: -1,
                    exp_err: 0, exp_nsamp: 1, exp_ts: 32'h87654321, exp_ch: 8'h07, exp_cnt: 8'd1,
                    exp_flags: 16'h8001, exp_good: 3, exp_bad: 4};

        rst = 1'b1; s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        #12;
        chk("rst s_tready", 32'(s_tready), 32'd0);
        chk("rst m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst m_tdata", m_tdata, 32'd0);
        chk("rst good_cnt", 32'(good_cnt), 32'd0);
        chk("rst pkt_timestamp", pkt_timestamp, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst s_tready", 32'(s_tready), 32'd1);

        // Table cases run back to back with no idle cycle between packets.
        for (int i = 0; i < 7; i++) begin
            build(vecs[i]);
            send_first(bq.size());
            check_case($sformatf("case%0d", i), vecs[i]);
        end

        // Downstream stall during payload.
        saw_stall = 1'b0;
        m_tready  = 1'b0;
        fork
            begin
                repeat (25) @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join_none
        build(vecs[0]);
        send_first(bq.size());
        chk("stall s_tready dropped", 32'(saw_stall), 32'd1);
        v = vecs[0];
        v.exp_good = 4;
        v.exp_bad  = 4;
        check_case("stall", v);

        // Reset while a sample is pending downstream.
        m_tready = 1'b0;
        build(vecs[0]);
        send_first(14);
        repeat (2) @(posedge clk);
        chk("pre-rst m_tvalid", 32'(m_tvalid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async-rst m_tvalid", 32'(m_tvalid), 32'd0);
        chk("async-rst m_tdata", m_tdata, 32'd0);
        chk("async-rst m_tuser", 32'(m_tuser), 32'd0);
        chk("async-rst s_tready", 32'(s_tready), 32'd0);
        chk("async-rst pkt_done", 32'(pkt_done), 32'd0);
        chk("async-rst good_cnt", 32'(good_cnt), 32'd0);
        chk("async-rst no_done_seen", 32'(dq_err.size()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_tready = 1'b1;
        clear_q();
        @(posedge clk); #1;
        build(vecs[0]);
        send_first(bq.size());
        v = vecs[0];
        v.exp_good = 1;
        v.exp_bad  = 0;
        check_case("after-rst", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
